// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller and its helpers.
package pong_pkg;

    // Match controller states; the encoding is visible on the debug/LED output.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } match_state_t;

    // Winner flag encoding.
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Default timing for a 27 MHz system clock.
    localparam int DEF_SERVE_CYCLES = 27_000_000;
    localparam int DEF_POINT_CYCLES = 54_000_000;
    localparam int DEF_WIN_SCORE    = 10;
    localparam int DEF_CNT_W        = 26;

    // Increment a score but never go past the winning score.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] top);
        return (score >= top) ? top : score + 4'd1;
    endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Bundle of the match controller's button, ball/bat control and score signals.
//
// Signalling: start_req and pause_req are single-cycle pulses sampled on every
// rising clk edge; oob/oob_right are levels, oob_right only meaningful while oob
// is high. Every output is a registered level except ball_rst and score_evt,
// which are single-cycle pulses. There is no back-pressure anywhere.
interface match_sequencer_if;
    logic       start_req;
    logic       pause_req;
    logic       oob;
    logic       oob_right;
    logic       ball_en;
    logic       ball_rst;
    logic       ball_vis;
    logic       bat_en;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;
    logic       score_evt;
    logic [2:0] state_o;

    // Side that supplies buttons and ball status and consumes the controls.
    modport master (
        output start_req, pause_req, oob, oob_right,
        input  ball_en, ball_rst, ball_vis, bat_en,
        input  p1_score, p2_score, winner, score_evt, state_o
    );

    // The match controller itself.
    modport slave (
        input  start_req, pause_req, oob, oob_right,
        output ball_en, ball_rst, ball_vis, bat_en,
        output p1_score, p2_score, winner, score_evt, state_o
    );
endinterface

// File: rtl/delay_timer.sv
// Shared delay counter: counts up from 0 after a clear and flags when it has
// reached limit-1, holding there until cleared again.
module delay_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count up while not expired; clear wins so every state entry starts at 0.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == limit - CNT_W'(1));

endmodule

// File: rtl/match_sequencer.sv
// Top-level pong match controller: sequences serve, play, point delay, pause
// and game over, gates the ball/bat datapaths and owns the scores and winner.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int SERVE_CYCLES = DEF_SERVE_CYCLES,
    parameter int POINT_CYCLES = DEF_POINT_CYCLES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    match_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] SERVE_LIM = CNT_W'(SERVE_CYCLES);
    localparam logic [CNT_W-1:0] POINT_LIM = CNT_W'(POINT_CYCLES);
    localparam logic [3:0]       WIN_LIM   = 4'(WIN_SCORE);

    match_state_t     state;
    match_state_t     next_state;
    logic             point_hit;
    logic             game_clear;
    logic             timer_clear;
    logic             timer_done;
    logic [CNT_W-1:0] timer_limit;
    logic [3:0]       p1_next;
    logic [3:0]       p2_next;

    // One timer serves both SERVE and POINT; it restarts on every state change
    // and is held at 0 in states that do not time anything.
    assign timer_clear = reset || (next_state != state) ||
                         !((state == SERVE) || (state == POINT));
    assign timer_limit = (state == POINT) ? POINT_LIM : SERVE_LIM;

    delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .clear (timer_clear),
        .limit (timer_limit),
        .done  (timer_done)
    );

    // Next-state decode; oob takes priority over a simultaneous pause in PLAY.
    always_comb begin
        next_state = state;
        point_hit  = 1'b0;
        game_clear = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_req) begin
                    next_state = SERVE;
                    game_clear = 1'b1;
                end
            end
            SERVE: begin
                if (timer_done) begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (bus.oob) begin
                    next_state = POINT;
                    point_hit  = 1'b1;
                end else if (bus.pause_req) begin
                    next_state = PAUSE;
                end
            end
            POINT: begin
                if (timer_done) begin
                    next_state = (bus.winner != WIN_NONE) ? OVER : SERVE;
                end
            end
            PAUSE: begin
                if (bus.pause_req) begin
                    next_state = PLAY;
                end
            end
            OVER: begin
                if (bus.start_req) begin
                    next_state = SERVE;
                    game_clear = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; reset aborts straight to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign bus.state_o = state;

    // Datapath controls are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ball_en  <= 1'b0;
            bus.ball_rst <= 1'b0;
            bus.ball_vis <= 1'b0;
            bus.bat_en   <= 1'b0;
        end else begin
            bus.ball_rst <= (next_state == SERVE) && (state != SERVE);
            case (next_state)
                SERVE: begin
                    bus.ball_en  <= 1'b0;
                    bus.ball_vis <= 1'b1;
                    bus.bat_en   <= 1'b1;
                end
                PLAY: begin
                    bus.ball_en  <= 1'b1;
                    bus.ball_vis <= 1'b1;
                    bus.bat_en   <= 1'b1;
                end
                POINT: begin
                    bus.ball_en  <= 1'b0;
                    bus.ball_vis <= 1'b0;
                    bus.bat_en   <= 1'b1;
                end
                PAUSE: begin
                    bus.ball_en  <= 1'b0;
                    bus.ball_vis <= 1'b1;
                    bus.bat_en   <= 1'b0;
                end
                default: begin
                    bus.ball_en  <= 1'b0;
                    bus.ball_vis <= 1'b0;
                    bus.bat_en   <= 1'b0;
                end
            endcase
        end
    end

    assign p1_next = sat_inc(bus.p1_score, WIN_LIM);
    assign p2_next = sat_inc(bus.p2_score, WIN_LIM);

    // Scoring: one increment on the PLAY->POINT edge, winner flagged in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || game_clear) begin
            bus.p1_score  <= 4'd0;
            bus.p2_score  <= 4'd0;
            bus.winner    <= WIN_NONE;
            bus.score_evt <= 1'b0;
        end else begin
            bus.score_evt <= point_hit;
            if (point_hit) begin
                if (bus.oob_right) begin
                    bus.p1_score <= p1_next;
                    if (p1_next == WIN_LIM) begin
                        bus.winner <= WIN_P1;
                    end
                end else begin
                    bus.p2_score <= p2_next;
                    if (p2_next == WIN_LIM) begin
                        bus.winner <= WIN_P2;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short serve/point delays and a
// three-point game.
module tb_match_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    match_sequencer_if bus ();

    match_sequencer #(
        .SERVE_CYCLES (4),
        .POINT_CYCLES (3),
        .WIN_SCORE    (3),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step until the DUT reaches a state, bounded by a cycle budget.
    task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state_o !== tgt && n < budget) begin
            step();
            n++;
        end
        chk(tag, 8'(bus.state_o), 8'(tgt));
    endtask

    // Driver: a single directed sequence of steps
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset         = 1'b1;
        bus.start_req = 1'b0;
        bus.pause_req = 1'b0;
        bus.oob       = 1'b0;
        bus.oob_right = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_state", 8'(bus.state_o), 8'(S_IDLE));
        chk("rst_p1", 8'(bus.p1_score), 8'd0);
        chk("rst_p2", 8'(bus.p2_score), 8'd0);
        chk("rst_winner", 8'(bus.winner), 8'd0);
        chk("rst_ball_en", 8'(bus.ball_en), 8'd0);
        chk("rst_ball_vis", 8'(bus.ball_vis), 8'd0);
        chk("rst_bat_en", 8'(bus.bat_en), 8'd0);
        chk("rst_ball_rst", 8'(bus.ball_rst), 8'd0);
        chk("rst_score_evt", 8'(bus.score_evt), 8'd0);

        // 1: start -> SERVE, ball_rst one cycle, ball_en rises 4 cycles after entry
        bus.start_req = 1'b1;
        step();
        bus.start_req = 1'b0;
        chk("t1_serve", 8'(bus.state_o), 8'(S_SERVE));
        chk("t1_ball_rst_hi", 8'(bus.ball_rst), 8'd1);
        chk("t1_vis", 8'(bus.ball_vis), 8'd1);
        chk("t1_bat", 8'(bus.bat_en), 8'd1);
        chk("t1_en_c0", 8'(bus.ball_en), 8'd0);
        step();
        chk("t1_ball_rst_lo", 8'(bus.ball_rst), 8'd0);
        step();
        step();
        chk("t1_en_c3", 8'(bus.ball_en), 8'd0);
        chk("t1_still_serve", 8'(bus.state_o), 8'(S_SERVE));
        step();
        chk("t1_en_c4", 8'(bus.ball_en), 8'd1);
        chk("t1_play", 8'(bus.state_o), 8'(S_PLAY));

        // 2: oob right held 5 cycles -> one point for P1
        bus.oob       = 1'b1;
        bus.oob_right = 1'b1;
        step();
        chk("t2_point", 8'(bus.state_o), 8'(S_POINT));
        chk("t2_p1", 8'(bus.p1_score), 8'd1);
        chk("t2_evt", 8'(bus.score_evt), 8'd1);
        chk("t2_vis0", 8'(bus.ball_vis), 8'd0);
        chk("t2_bat1", 8'(bus.bat_en), 8'd1);
        step();
        chk("t2_evt_once", 8'(bus.score_evt), 8'd0);
        chk("t2_vis1", 8'(bus.ball_vis), 8'd0);
        step();
        chk("t2_vis2", 8'(bus.ball_vis), 8'd0);
        chk("t2_p1_held", 8'(bus.p1_score), 8'd1);
        step();
        chk("t2_serve", 8'(bus.state_o), 8'(S_SERVE));
        chk("t2_vis_back", 8'(bus.ball_vis), 8'd1);
        chk("t2_ball_rst", 8'(bus.ball_rst), 8'd1);
        step();
        bus.oob = 1'b0;
        chk("t2_p1_final", 8'(bus.p1_score), 8'd1);
        chk("t2_p2_zero", 8'(bus.p2_score), 8'd0);
        wait_state(S_PLAY, 10, "t2_to_play");

        // 3: three left misses -> P2 wins
        bus.oob_right = 1'b0;
        bus.oob = 1'b1;
        step();
        bus.oob = 1'b0;
        chk("t3_p2_a", 8'(bus.p2_score), 8'd1);
        chk("t3_win_a", 8'(bus.winner), 8'd0);
        wait_state(S_PLAY, 12, "t3_play_a");
        bus.oob = 1'b1;
        step();
        bus.oob = 1'b0;
        chk("t3_p2_b", 8'(bus.p2_score), 8'd2);
        wait_state(S_PLAY, 12, "t3_play_b");
        bus.oob = 1'b1;
        step();
        bus.oob = 1'b0;
        chk("t3_p2_c", 8'(bus.p2_score), 8'd3);
        chk("t3_winner", 8'(bus.winner), 8'd2);
        chk("t3_in_point", 8'(bus.state_o), 8'(S_POINT));
        wait_state(S_OVER, 8, "t3_over");
        chk("t3_over_vis", 8'(bus.ball_vis), 8'd0);
        chk("t3_over_bat", 8'(bus.bat_en), 8'd0);
        chk("t3_over_p1", 8'(bus.p1_score), 8'd1);
        bus.oob = 1'b1;
        step();
        bus.oob = 1'b0;
        chk("t3_sat_p2", 8'(bus.p2_score), 8'd3);
        chk("t3_sat_evt", 8'(bus.score_evt), 8'd0);
        chk("t3_still_over", 8'(bus.state_o), 8'(S_OVER));
        chk("t3_win_held", 8'(bus.winner), 8'd2);
        bus.start_req = 1'b1;
        step();
        bus.start_req = 1'b0;
        chk("t3_restart", 8'(bus.state_o), 8'(S_SERVE));
        chk("t3_clr_p1", 8'(bus.p1_score), 8'd0);
        chk("t3_clr_p2", 8'(bus.p2_score), 8'd0);
        chk("t3_clr_win", 8'(bus.winner), 8'd0);

        // 4: pause in PLAY; oob ignored while paused; start ignored in PLAY
        wait_state(S_PLAY, 10, "t4_play");
        bus.start_req = 1'b1;
        step();
        bus.start_req = 1'b0;
        chk("t4_start_ign", 8'(bus.state_o), 8'(S_PLAY));
        bus.pause_req = 1'b1;
        step();
        bus.pause_req = 1'b0;
        chk("t4_pause", 8'(bus.state_o), 8'(S_PAUSE));
        chk("t4_ball_en", 8'(bus.ball_en), 8'd0);
        chk("t4_bat_en", 8'(bus.bat_en), 8'd0);
        chk("t4_vis", 8'(bus.ball_vis), 8'd1);
        bus.oob       = 1'b1;
        bus.oob_right = 1'b1;
        step();
        bus.oob = 1'b0;
        chk("t4_oob_p1", 8'(bus.p1_score), 8'd0);
        chk("t4_oob_p2", 8'(bus.p2_score), 8'd0);
        chk("t4_oob_evt", 8'(bus.score_evt), 8'd0);
        chk("t4_oob_state", 8'(bus.state_o), 8'(S_PAUSE));
        bus.pause_req = 1'b1;
        step();
        bus.pause_req = 1'b0;
        chk("t4_resume", 8'(bus.state_o), 8'(S_PLAY));
        chk("t4_resume_en", 8'(bus.ball_en), 8'd1);

        // 5: pause and oob together -> oob wins
        bus.pause_req = 1'b1;
        bus.oob       = 1'b1;
        bus.oob_right = 1'b1;
        step();
        bus.pause_req = 1'b0;
        bus.oob       = 1'b0;
        chk("t5_point", 8'(bus.state_o), 8'(S_POINT));
        chk("t5_p1", 8'(bus.p1_score), 8'd1);
        chk("t5_evt", 8'(bus.score_evt), 8'd1);
        step();
        chk("t5_no_pause", 8'(bus.state_o), 8'(S_POINT));

        // 6: reset mid-POINT with p1_score=2
        wait_state(S_PLAY, 12, "t6_play");
        bus.oob = 1'b1;
        step();
        bus.oob = 1'b0;
        chk("t6_p1_two", 8'(bus.p1_score), 8'd2);
        step();
        chk("t6_mid_point", 8'(bus.state_o), 8'(S_POINT));
        reset   = 1'b1;
        bus.oob = 1'b1;
        step();
        reset   = 1'b0;
        bus.oob = 1'b0;
        chk("t6_idle", 8'(bus.state_o), 8'(S_IDLE));
        chk("t6_p1_clr", 8'(bus.p1_score), 8'd0);
        chk("t6_vis", 8'(bus.ball_vis), 8'd0);
        chk("t6_evt", 8'(bus.score_evt), 8'd0);
        chk("t6_bat", 8'(bus.bat_en), 8'd0);
        step();
        chk("t6_stay_idle", 8'(bus.state_o), 8'(S_IDLE));

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
